// File: rtl/mpsram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mpsram_arbiter
// Purpose  : Round-robin arbiter sharing a dual-port SRAM array. Port A
//            serves write requesters and port B serves read requesters. A read
//            that targets the address being written in the same cycle is held
//            off one cycle. Read data is returned tagged with the requester id.
// Revision : 1.0 - initial release
// ============================================================================
module mpsram_arbiter #(
   parameter int NWR       = 16,
   parameter int NRD       = 16,
   parameter int DWIDTH    = 32,
   parameter int NRAMWIDHT = 5,
   parameter int AWIDTH    = 13,
   localparam int AW       = NRAMWIDHT + AWIDTH,
   localparam int WIDW     = $clog2(NWR),
   localparam int WIDR     = $clog2(NRD)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [NWR-1:0]        wr_req_in,
   input  logic [NWR*AW-1:0]     wr_addr_in,
   input  logic [NWR*DWIDTH-1:0] wr_data_in,
   output logic [NWR-1:0]        wr_gnt_out,
   input  logic [NRD-1:0]        rd_req_in,
   input  logic [NRD*AW-1:0]     rd_addr_in,
   output logic [NRD-1:0]        rd_gnt_out,
   output logic                  rd_valid_out,
   output logic [WIDR-1:0]       rd_id_out,
   output logic [DWIDTH-1:0]     rd_data_out,
   output logic                  sram_en_a_out,
   output logic                  sram_we_a_out,
   output logic [AW-1:0]         sram_addr_a_out,
   output logic [DWIDTH-1:0]     sram_d_a_out,
   output logic                  sram_en_b_out,
   output logic                  sram_we_b_out,
   output logic [AW-1:0]         sram_addr_b_out,
   input  logic [DWIDTH-1:0]     sram_d_b_in
);

   logic [WIDW-1:0]   wptr;
   logic [WIDR-1:0]   rptr;
   logic [WIDW-1:0]   wr_sel;
   logic [WIDR-1:0]   rd_sel;
   logic [WIDW:0]     wr_idx;
   logic [WIDR:0]     rd_idx;
   logic              wr_found;
   logic              rd_found;
   logic              wr_any;
   logic              rd_any;
   logic              collision;
   logic [AW-1:0]     rd_cand_addr;

   // Write candidate: first requester at or after wptr, wrapping modulo NWR
   always_comb begin
      wr_found = 1'b0;
      wr_sel   = '0;
      wr_idx   = '0;
      for (int k = 0; k < NWR; k++) begin
         wr_idx = {1'b0, wptr} + (WIDW+1)'(k);
         if (wr_idx >= (WIDW+1)'(NWR))
            wr_idx = wr_idx - (WIDW+1)'(NWR);
         if (!wr_found && wr_req_in[wr_idx[WIDW-1:0]]) begin
            wr_found = 1'b1;
            wr_sel   = wr_idx[WIDW-1:0];
         end
      end
   end

   // Read candidate: same search over rd_req_in starting at rptr
   always_comb begin
      rd_found = 1'b0;
      rd_sel   = '0;
      rd_idx   = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_idx = {1'b0, rptr} + (WIDR+1)'(k);
         if (rd_idx >= (WIDR+1)'(NRD))
            rd_idx = rd_idx - (WIDR+1)'(NRD);
         if (!rd_found && rd_req_in[rd_idx[WIDR-1:0]]) begin
            rd_found = 1'b1;
            rd_sel   = rd_idx[WIDR-1:0];
         end
      end
   end

   // Write grant and port A mux; grants are forced low during reset
   always_comb begin
      wr_gnt_out      = '0;
      sram_addr_a_out = '0;
      sram_d_a_out    = '0;
      wr_any          = wr_found && !rst_in;
      if (wr_any) begin
         for (int i = 0; i < NWR; i++) begin
            if (wr_sel == WIDW'(i)) begin
               wr_gnt_out[i]   = 1'b1;
               sram_addr_a_out = wr_addr_in[i*AW +: AW];
               sram_d_a_out    = wr_data_in[i*DWIDTH +: DWIDTH];
            end
         end
      end
      sram_en_a_out = wr_any;
      sram_we_a_out = wr_any;
   end

   // Read grant with collision hold-off; the write always wins a same-address clash
   always_comb begin
      rd_cand_addr = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rd_sel == WIDR'(i))
            rd_cand_addr = rd_addr_in[i*AW +: AW];
      end
      collision       = wr_any && (rd_cand_addr == sram_addr_a_out);
      rd_any          = rd_found && !collision && !rst_in;
      rd_gnt_out      = '0;
      sram_addr_b_out = '0;
      if (rd_any) begin
         rd_gnt_out[rd_sel] = 1'b1;
         sram_addr_b_out    = rd_cand_addr;
      end
      sram_en_b_out = rd_any;
      sram_we_b_out = 1'b0;
   end

   // Round-robin pointers advance past the granted index; hold when nothing granted
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_any)
            wptr <= (wr_sel == WIDW'(NWR-1)) ? '0 : wr_sel + 1'b1;
         if (rd_any)
            rptr <= (rd_sel == WIDR'(NRD-1)) ? '0 : rd_sel + 1'b1;
      end
   end

   // Return stage aligned with the one-cycle SRAM read latency
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rd_valid_out <= 1'b0;
         rd_id_out    <= '0;
      end else begin
         rd_valid_out <= rd_any;
         if (rd_any)
            rd_id_out <= rd_sel;
      end
   end

   assign rd_data_out = rd_valid_out ? sram_d_b_in : '0;

endmodule
`default_nettype wire

// File: tb/tb_mpsram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpsram_arbiter
// Purpose  : Self-checking bench for mpsram_arbiter with a behavioural SRAM
//            and a queue of expected read returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpsram_arbiter;

   localparam int NWR    = 4;
   localparam int NRD    = 8;
   localparam int DWIDTH = 32;
   localparam int NRAMW  = 5;
   localparam int AWID   = 13;
   localparam int AW     = NRAMW + AWID;
   localparam int WIDR   = $clog2(NRD);

   typedef struct {
      logic [WIDR-1:0]   id;
      logic [DWIDTH-1:0] data;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NWR-1:0]        wr_req = '0;
   logic [NWR*AW-1:0]     wr_addr = '0;
   logic [NWR*DWIDTH-1:0] wr_data = '0;
   logic [NWR-1:0]        wr_gnt;
   logic [NRD-1:0]        rd_req = '0;
   logic [NRD*AW-1:0]     rd_addr = '0;
   logic [NRD-1:0]        rd_gnt;
   logic                  rd_valid;
   logic [WIDR-1:0]       rd_id;
   logic [DWIDTH-1:0]     rd_data;
   logic                  en_a, we_a, en_b, we_b;
   logic [AW-1:0]         addr_a, addr_b;
   logic [DWIDTH-1:0]     d_a;
   logic [DWIDTH-1:0]     d_b = '0;

   logic [DWIDTH-1:0]     mem [logic [AW-1:0]];
   exp_t                  sb[$];
   exp_t                  e;
   int                    n_checks = 0;
   int                    n_pass   = 0;

   mpsram_arbiter #(
      .NWR(NWR), .NRD(NRD), .DWIDTH(DWIDTH), .NRAMWIDHT(NRAMW), .AWIDTH(AWID)
   ) dut (
      .clk_in(clk), .rst_in(rst),
      .wr_req_in(wr_req), .wr_addr_in(wr_addr), .wr_data_in(wr_data), .wr_gnt_out(wr_gnt),
      .rd_req_in(rd_req), .rd_addr_in(rd_addr), .rd_gnt_out(rd_gnt),
      .rd_valid_out(rd_valid), .rd_id_out(rd_id), .rd_data_out(rd_data),
      .sram_en_a_out(en_a), .sram_we_a_out(we_a), .sram_addr_a_out(addr_a), .sram_d_a_out(d_a),
      .sram_en_b_out(en_b), .sram_we_b_out(we_b), .sram_addr_b_out(addr_b), .sram_d_b_in(d_b)
   );

   always #5 clk = ~clk;

   // Behavioural dual-port SRAM: port B reads with one cycle latency
   always @(posedge clk) begin
      if (en_b)
         d_b <= mem.exists(addr_b) ? mem[addr_b] : '0;
      if (en_a && we_a)
         mem[addr_a] = d_a;
   end

   task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DWIDTH-1:0] d);
      wr_addr[i*AW +: AW]         = a;
      wr_data[i*DWIDTH +: DWIDTH] = d;
   endtask

   task automatic set_rd(input int i, input logic [AW-1:0] a);
      rd_addr[i*AW +: AW] = a;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      wr_req = '0;
      rd_req = '0;
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic pop_return(input string name);
      n_checks++;
      if (rd_valid !== 1'b1) begin
         $display("FAIL %s_valid: got %b want 1", name, rd_valid);
      end else if (sb.size() == 0) begin
         $display("FAIL %s_sb: return with no expectation queued", name);
      end else begin
         e = sb.pop_front();
         if (rd_id !== e.id || rd_data !== e.data)
            $display("FAIL %s_data: got id=%0d data=%h want id=%0d data=%h",
                     name, rd_id, rd_data, e.id, e.data);
         else
            n_pass++;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < NWR; i++) set_wr(i, AW'(18'h01000 + i), 32'hA000_0000 + i);
      for (int i = 0; i < NRD; i++) set_rd(i, AW'(18'h03000 + i));
      wr_req = '1;
      rd_req = '1;
      @(negedge clk);
      n_checks++;
      if (wr_gnt !== '0 || rd_gnt !== '0 || en_a !== 1'b0 || en_b !== 1'b0)
         $display("FAIL rst_hold: got wg=%b rg=%b ena=%b enb=%b want all 0", wr_gnt, rd_gnt, en_a, en_b);
      else n_pass++;
      n_checks++;
      if (rd_valid !== 1'b0 || rd_id !== '0 || rd_data !== '0)
         $display("FAIL rst_ret: got v=%b id=%0d d=%h want 0", rd_valid, rd_id, rd_data);
      else n_pass++;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wr_gnt !== 4'b0001 || rd_gnt !== 8'b0000_0001)
         $display("FAIL rst_first_gnt: got wg=%b rg=%b want 0001 00000001", wr_gnt, rd_gnt);
      else n_pass++;
      next_cycle();
      n_checks++;
      if (rd_valid !== 1'b1)
         $display("FAIL rst_pre_valid: got %b want 1", rd_valid);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (wr_gnt !== '0 || rd_gnt !== '0 || en_a !== 1'b0 || en_b !== 1'b0 || rd_valid !== 1'b0)
         $display("FAIL rst_async: got wg=%b rg=%b ena=%b enb=%b v=%b want all 0",
                  wr_gnt, rd_gnt, en_a, en_b, rd_valid);
      else n_pass++;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wr_gnt !== 4'b0001 || rd_gnt !== 8'b0000_0001)
         $display("FAIL rst_regrant: got wg=%b rg=%b want 0001 00000001", wr_gnt, rd_gnt);
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_write_rr();
      logic [NWR-1:0] exp_g;
      apply_reset();
      for (int i = 0; i < NWR; i++) set_wr(i, AW'(18'h00400 + 18'(i) * 18'h111), 32'hC0DE_0000 + i);
      wr_req = '1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_g = NWR'(1) << (c % NWR);
         n_checks++;
         if (wr_gnt !== exp_g || en_a !== 1'b1 || we_a !== 1'b1)
            $display("FAIL wrr_gnt%0d: got g=%b en=%b we=%b want g=%b en=1 we=1", c, wr_gnt, en_a, we_a, exp_g);
         else n_pass++;
         n_checks++;
         if (addr_a !== AW'(18'h00400 + 18'(c % NWR) * 18'h111) || d_a !== 32'hC0DE_0000 + (c % NWR))
            $display("FAIL wrr_addr%0d: got a=%h d=%h want a=%h d=%h", c, addr_a, d_a,
                     AW'(18'h00400 + 18'(c % NWR) * 18'h111), 32'hC0DE_0000 + (c % NWR));
         else n_pass++;
         next_cycle();
      end
      wr_req = '0;
      @(negedge clk);
      n_checks++;
      if (wr_gnt !== '0 || en_a !== 1'b0 || addr_a !== '0 || d_a !== '0)
         $display("FAIL wrr_idle: got g=%b en=%b a=%h d=%h want 0", wr_gnt, en_a, addr_a, d_a);
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_pointer_skip();
      logic [NWR-1:0] exp_seq [3];
      exp_seq[0] = 4'b1000;
      exp_seq[1] = 4'b0001;
      exp_seq[2] = 4'b1000;
      apply_reset();
      wr_req = 4'b0010;
      @(negedge clk);
      n_checks++;
      if (wr_gnt !== 4'b0010) $display("FAIL skip_setup: got %b want 0010", wr_gnt);
      else n_pass++;
      next_cycle();
      wr_req = 4'b1001;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (wr_gnt !== exp_seq[c]) $display("FAIL skip_%0d: got %b want %b", c, wr_gnt, exp_seq[c]);
         else n_pass++;
         next_cycle();
      end
      wr_req = '0;
   endtask

   task automatic test_read_latency();
      apply_reset();
      set_wr(2, 18'h20005, 32'hDEAD_BEEF);
      wr_req = 4'b0100;
      @(negedge clk);
      n_checks++;
      if (wr_gnt !== 4'b0100 || addr_a !== 18'h20005 || d_a !== 32'hDEAD_BEEF)
         $display("FAIL lat_wr: got g=%b a=%h d=%h want 0100 20005 deadbeef", wr_gnt, addr_a, d_a);
      else n_pass++;
      next_cycle();
      wr_req = '0;
      set_rd(5, 18'h20005);
      rd_req = 8'b0010_0000;
      @(negedge clk);
      n_checks++;
      if (rd_gnt !== 8'b0010_0000 || en_b !== 1'b1 || we_b !== 1'b0 || addr_b !== 18'h20005 || rd_valid !== 1'b0)
         $display("FAIL lat_gnt: got g=%b en=%b we=%b a=%h v=%b want 00100000 1 0 20005 0",
                  rd_gnt, en_b, we_b, addr_b, rd_valid);
      else n_pass++;
      sb.push_back('{id: WIDR'(5), data: 32'hDEAD_BEEF});
      next_cycle();
      rd_req = '0;
      @(negedge clk);
      pop_return("lat");
      next_cycle();
   endtask

   task automatic test_collision();
      apply_reset();
      set_wr(0, 18'h00100, 32'h0000_0011);
      set_rd(3, 18'h00100);
      set_rd(6, 18'h00200);
      wr_req = 4'b0001;
      rd_req = 8'b0100_1000;
      @(negedge clk);
      n_checks++;
      if (wr_gnt !== 4'b0001 || rd_gnt !== '0 || en_b !== 1'b0)
         $display("FAIL col_hold: got wg=%b rg=%b enb=%b want 0001 0 0", wr_gnt, rd_gnt, en_b);
      else n_pass++;
      next_cycle();
      wr_req = '0;
      @(negedge clk);
      n_checks++;
      if (rd_gnt !== 8'b0000_1000 || addr_b !== 18'h00100 || rd_valid !== 1'b0)
         $display("FAIL col_next: got g=%b a=%h v=%b want 00001000 00100 0", rd_gnt, addr_b, rd_valid);
      else n_pass++;
      sb.push_back('{id: WIDR'(3), data: 32'h0000_0011});
      next_cycle();
      rd_req = '0;
      @(negedge clk);
      pop_return("col");
      next_cycle();
   endtask

   task automatic test_dual_port();
      apply_reset();
      set_wr(1, 18'h00011, 32'h5555_5555);
      wr_req = 4'b0010;
      next_cycle();
      set_wr(1, 18'h00010, 32'hA5A5_A5A5);
      set_rd(2, 18'h00011);
      rd_req = 8'b0000_0100;
      @(negedge clk);
      n_checks++;
      if (wr_gnt !== 4'b0010 || rd_gnt !== 8'b0000_0100 || en_a !== 1'b1 || en_b !== 1'b1)
         $display("FAIL dual_gnt: got wg=%b rg=%b ena=%b enb=%b want 0010 00000100 1 1",
                  wr_gnt, rd_gnt, en_a, en_b);
      else n_pass++;
      sb.push_back('{id: WIDR'(2), data: 32'h5555_5555});
      next_cycle();
      wr_req = '0;
      set_rd(2, 18'h00010);
      @(negedge clk);
      pop_return("dual");
      sb.push_back('{id: WIDR'(2), data: 32'hA5A5_A5A5});
      next_cycle();
      rd_req = '0;
      @(negedge clk);
      pop_return("dual_new");
      next_cycle();
   endtask

   initial begin
      next_cycle();
      test_reset();
      test_write_rr();
      test_pointer_skip();
      test_read_latency();
      test_collision();
      test_dual_port();
      n_checks++;
      if (sb.size() != 0) $display("FAIL sb_empty: got %0d pending want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
